prio_arb_rr: RTL and testbench

- Parametrised, registered successor to the combinational 8x3 priority encoder.
- Accepts N request lines and encodes one winner into an index plus a one-hot grant.
- Arbitration is either fixed priority (highest index wins) or rotating round-robin.
- The grant is held under a valid/ready handshake until a downstream consumer takes it; used wherever several sources share one sink.

---
 rtl/prio_arb_rr.sv | 128 ++++++++++++
 tb/tb_prio_arb_rr.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/prio_arb_rr.sv
// prio_arb_rr: registered N-way arbiter with fixed-priority or round-robin
// selection. The winner is held under a valid/ready handshake; on acceptance
// the arbiter re-arbitrates in the same edge so a ready consumer sees one
// grant per cycle.
module prio_arb_rr #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             gnt_ready,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     gnt_onehot,
    output logic             no_req
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [IDX_W-1:0] TOP = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     onehot_q, onehot_d;
    logic             no_req_q, no_req_d;

    logic [IDX_W-1:0] ptr_nx;
    logic [IDX_W-1:0] start;
    logic [IDX_W:0]   pick_res;
    logic             arb_en;

    // Search s, s-1, ..., 0, N-1, ..., s+1; returns {found, index}.
    function automatic logic [IDX_W:0] pick(input logic [N-1:0] r,
                                            input logic [IDX_W-1:0] s);
        logic             found;
        logic [IDX_W-1:0] win;
        int unsigned      sp;
        int unsigned      pos;
        found = 1'b0;
        win   = '0;
        sp    = 32'(s);
        for (int unsigned i = 0; i < N; i++) begin
            pos = (sp + N - i) % N;
            if (!found && (|(r & (N'(1) << pos)))) begin
                found = 1'b1;
                win   = IDX_W'(pos);
            end
        end
        return {found, win};
    endfunction

    // Next-state: arbitrate from IDLE, or on acceptance with the updated pointer.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        no_req_d = no_req_q;
        ptr_nx   = ptr_q;
        arb_en   = 1'b0;

        case (state_q)
            IDLE: arb_en = 1'b1;
            HOLD: begin
                if (gnt_ready) begin
                    arb_en = 1'b1;
                    if (mode) begin
                        ptr_nx = (idx_q == '0) ? TOP : idx_q - IDX_W'(1);
                    end
                end
            end
            default: arb_en = 1'b0;
        endcase

        start    = mode ? ptr_nx : TOP;
        pick_res = pick(req, start);

        if (arb_en) begin
            if (pick_res[IDX_W]) begin
                state_d  = HOLD;
                valid_d  = 1'b1;
                idx_d    = pick_res[IDX_W-1:0];
                onehot_d = N'(1) << pick_res[IDX_W-1:0];
                no_req_d = 1'b0;
            end else begin
                // gnt_idx keeps its last value when going idle
                state_d  = IDLE;
                valid_d  = 1'b0;
                onehot_d = '0;
                no_req_d = 1'b1;
            end
        end
        ptr_d = ptr_nx;
    end

    // State and registered outputs; async reset drops any held grant at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= TOP;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            no_req_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            no_req_q <= no_req_d;
        end
    end

    assign gnt_valid  = valid_q;
    assign gnt_idx    = idx_q;
    assign gnt_onehot = onehot_q;
    assign no_req     = no_req_q;

endmodule

// File: tb/tb_prio_arb_rr.sv
// tb_prio_arb_rr: drives an N=8 and an N=5 arbiter from shared stimulus and
// compares both against a behavioural model of the arbitration rules.
module tb_prio_arb_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic       gnt_ready;
    logic [7:0] req;

    logic       va, vb;
    logic [2:0] ia, ib;
    logic [7:0] oa;
    logic [4:0] ob;
    logic       na, nb;

    always #5 clk = ~clk;

    prio_arb_rr #(.N(8), .IDX_W(3)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .mode       (mode),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (va),
        .gnt_idx    (ia),
        .gnt_onehot (oa),
        .no_req     (na)
    );

    prio_arb_rr #(.N(5), .IDX_W(3)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req[4:0]),
        .mode       (mode),
        .gnt_ready  (gnt_ready),
        .gnt_valid  (vb),
        .gnt_idx    (ib),
        .gnt_onehot (ob),
        .no_req     (nb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state per instance: 0 -> N=8, 1 -> N=5
    int nn[2] = '{8, 5};
    int m_valid[2];
    int m_idx[2];
    int m_ptr[2];
    int m_noreq[2];

    // Winner = set bit closest to s going downward with wrap.
    function automatic int winner(input logic [7:0] r, input int s, input int n);
        int best, bestd, d;
        best  = -1;
        bestd = n;
        for (int k = 0; k < n; k++) begin
            d = (s - k + n) % n;
            if (r[k] && d < bestd) begin
                best  = k;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0;
            m_idx[i]   = 0;
            m_ptr[i]   = nn[i] - 1;
            m_noreq[i] = 1;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int n, s, w;
            logic [7:0] r;
            n = nn[i];
            r = (i == 0) ? req : {3'b000, req[4:0]};
            if (m_valid[i] == 0) begin
                s = mode ? m_ptr[i] : n - 1;
                w = winner(r, s, n);
                if (w >= 0) begin
                    m_valid[i] = 1;
                    m_idx[i]   = w;
                    m_noreq[i] = 0;
                end else begin
                    m_noreq[i] = 1;
                end
            end else if (gnt_ready) begin
                if (mode) m_ptr[i] = (m_idx[i] == 0) ? n - 1 : m_idx[i] - 1;
                s = mode ? m_ptr[i] : n - 1;
                w = winner(r, s, n);
                if (w >= 0) begin
                    m_idx[i]   = w;
                    m_noreq[i] = 0;
                end else begin
                    m_valid[i] = 0;
                    m_noreq[i] = 1;
                end
            end
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".a.valid"},  32'(va), m_valid[0]);
        check({tag, ".a.idx"},    32'(ia), m_idx[0]);
        check({tag, ".a.onehot"}, 32'(oa), m_valid[0] != 0 ? (1 << m_idx[0]) : 0);
        check({tag, ".a.no_req"}, 32'(na), m_noreq[0]);
        check({tag, ".b.valid"},  32'(vb), m_valid[1]);
        check({tag, ".b.idx"},    32'(ib), m_idx[1]);
        check({tag, ".b.onehot"}, 32'(ob), m_valid[1] != 0 ? (1 << m_idx[1]) : 0);
        check({tag, ".b.no_req"}, 32'(nb), m_noreq[1]);
        check({tag, ".b.idx_range"}, 32'(ib < 3'd5), 1);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare(tag);
    endtask

    // Reset is pulsed between clock edges and checked while still asserted.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare(tag);
        check({tag, ".a.valid0"}, 32'(va), 0);
        check({tag, ".a.no_req1"}, 32'(na), 1);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        req       = '0;
        mode      = 1'b0;
        gnt_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset");

        // Fixed priority
        mode = 1'b0; gnt_ready = 1'b1;
        req = 8'b10000011; cyc("fp0");
        check("fp0.idx7", 32'(ia), 7);
        check("fp0.oh80", 32'(oa), 32'h80);
        req = 8'b00111000; cyc("fp1");
        check("fp1.idx5", 32'(ia), 5);
        req = 8'b01010101; cyc("fp2");
        check("fp2.idx6", 32'(ia), 6);

        // Single-bit sweep
        for (int k = 0; k < 8; k++) begin
            req = 8'(1 << k);
            cyc("sweep");
            check("sweep.idx", 32'(ia), k);
        end
        req = '0; cyc("sweep_none");
        check("sweep_none.valid", 32'(va), 0);
        check("sweep_none.no_req", 32'(na), 1);

        // Round-robin rotation, both widths
        do_reset("reset_rr");
        mode = 1'b1; req = 8'hFF; gnt_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            cyc("rr");
            check("rr.a.seq", 32'(ia), 7 - (j % 8));
            check("rr.a.valid", 32'(va), 1);
            check("rr.b.seq", 32'(ib), 4 - (j % 5));
        end

        // Backpressure with sticky grant
        do_reset("reset_bp");
        mode = 1'b1; req = 8'b00001111; gnt_ready = 1'b0;
        cyc("bp_first");
        for (int j = 0; j < 4; j++) begin
            if (j == 1) req = 8'b00000111;
            cyc("bp_hold");
            check("bp.idx3", 32'(ia), 3);
            check("bp.oh08", 32'(oa), 32'h08);
        end
        gnt_ready = 1'b1; cyc("bp_release");
        check("bp.next2", 32'(ia), 2);

        // Async reset while holding idx 4
        mode = 1'b0; req = 8'h10; gnt_ready = 1'b1; cyc("ar_setup");
        gnt_ready = 1'b0; cyc("ar_hold");
        check("ar.idx4", 32'(ia), 4);
        do_reset("ar_reset");
        mode = 1'b1; req = 8'hFF; gnt_ready = 1'b1; cyc("ar_after");
        check("ar.first7", 32'(ia), 7);

        // Random traffic
        do_reset("reset_rand");
        for (int t = 0; t < 500; t++) begin
            case ($urandom_range(0, 3))
                0:       req = 8'(1 << $urandom_range(0, 7));
                1:       req = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                default: req = 8'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            gnt_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) == 0) do_reset("rand_reset");
            else cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
